// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store sequencer: access sizes, FSM states
// and the lane-decode helpers used by both the sequencer and the aligner.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StLoad,
        StCapture,
        StFinish
    } state_e;

    // Byte-lane select for an access of the given size at the given offset.
    function automatic logic [3:0] sel_from_size(input logic [1:0] size,
                                                 input logic [1:0] offset);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << offset;
            SZ_HALF: sel = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Reserved size is always rejected; halves need even, words zero offset.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Replicate right-justified store data across every lane so the memory
    // picks the right bytes purely from sel.
    function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                                input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load alignment: shifts the addressed bytes of a memory word
// down to bit 0 and zero- or sign-extends them to 32 bits.
module load_aligner
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {offset_i, 3'b000};

    // Extend the shifted field according to access size and sign mode.
    always_comb begin
        result_o = word_i;
        case (size_i)
            SZ_BYTE: result_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a word-organised data
// memory with registered read data. Misaligned requests are rejected without
// any memory strobe.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W+1:0] byte_addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_datain_o,
    output logic              mem_str_o,
    output logic              mem_ld_o,
    input  logic [31:0]       mem_dataout_i
);

    state_e            state_q, state_d;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              reject_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_misaligned;
    logic [31:0]       aligned;

    assign accept         = (state_q == StIdle) && req_i;
    assign req_misaligned = is_misaligned(size_i, byte_addr_i[1:0]);

    // State register; reset drops the strobes immediately since they decode state.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request on acceptance; direction is carried by the state itself.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            size_q     <= SZ_BYTE;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            reject_q   <= 1'b0;
        end else if (accept) begin
            size_q     <= size_i;
            sign_ext_q <= sign_ext_i;
            addr_q     <= byte_addr_i;
            wdata_q    <= wdata_i;
            reject_q   <= req_misaligned;
        end
    end

    // Next-state sequencing: one cycle per phase, requests ignored when busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (req_misaligned) begin
                        state_d = StFinish;
                    end else if (we_i) begin
                        state_d = StStore;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StStore:   state_d = StFinish;
            StLoad:    state_d = StCapture;
            StCapture: state_d = StFinish;
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Memory-side outputs decoded from state; everything is zero outside STORE/LOAD.
    always_comb begin
        mem_str_o    = 1'b0;
        mem_ld_o     = 1'b0;
        mem_addr_o   = '0;
        mem_sel_o    = 4'b0000;
        mem_datain_o = '0;
        case (state_q)
            StStore: begin
                mem_str_o    = 1'b1;
                mem_addr_o   = addr_q[ADDR_W+1:2];
                mem_sel_o    = sel_from_size(size_q, addr_q[1:0]);
                mem_datain_o = store_lanes(size_q, wdata_q);
            end
            StLoad: begin
                mem_ld_o   = 1'b1;
                mem_addr_o = addr_q[ADDR_W+1:2];
                mem_sel_o  = sel_from_size(size_q, addr_q[1:0]);
            end
            default: begin
                mem_str_o = 1'b0;
            end
        endcase
    end

    load_aligner u_load_aligner (
        .word_i     (mem_dataout_i),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .sign_ext_i (sign_ext_q),
        .result_o   (aligned)
    );

    // Load result register: only CAPTURE updates it, so rejects leave it untouched.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            rdata_q <= '0;
        end else if (state_q == StCapture) begin
            rdata_q <= aligned;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign done_o     = (state_q == StFinish);
    assign misalign_o = (state_q == StFinish) && reject_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a word memory with registered
// read data, and a byte-array reference model of what loads should return.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 12;

    logic              clk;
    logic              clr;
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W+1:0] byte_addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              misalign;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_sel;
    logic [31:0]       mem_datain;
    logic              mem_str;
    logic              mem_ld;
    logic [31:0]       mem_dataout;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0]  ref_mem [0:(1<<(ADDR_W+2))-1];
    logic [31:0] exp_rdata;

    int checks;
    int failures;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i         (clk),
        .clr_i         (clr),
        .req_i         (req),
        .we_i          (we),
        .size_i        (size),
        .sign_ext_i    (sign_ext),
        .byte_addr_i   (byte_addr),
        .wdata_i       (wdata),
        .ready_o       (ready),
        .done_o        (done),
        .misalign_o    (misalign),
        .rdata_o       (rdata),
        .mem_addr_o    (mem_addr),
        .mem_sel_o     (mem_sel),
        .mem_datain_o  (mem_datain),
        .mem_str_o     (mem_str),
        .mem_ld_o      (mem_ld),
        .mem_dataout_i (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: lane-masked writes, registered read data.
    always @(posedge clk) begin
        if (mem_str) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_sel[l]) mem[mem_addr][8*l +: 8] <= mem_datain[8*l +: 8];
            end
        end
        if (mem_ld) mem_dataout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (off % 2) != 0;
        if (sz == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    // Assemble little-endian bytes from the reference and extend them.
    function automatic logic [31:0] ref_load(input logic [13:0] ba, input logic [1:0] sz,
                                             input logic sx);
        int n = 1 << sz;
        logic [31:0] val = '0;
        for (int i = 0; i < n; i++) val = val | (32'(ref_mem[int'(ba) + i]) << (8 * i));
        if (sx && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
        return val;
    endfunction

    // One complete access; with hold=1 req stays high and the bench stops on the done cycle.
    task automatic access(input logic a_we, input logic [1:0] a_sz, input logic a_sx,
                          input logic [13:0] a_ba, input logic [31:0] a_wd, input bit hold);
        logic        mis;
        int          n;
        int          exp_lat;
        int          lat;
        int          nstr;
        int          nld;
        logic [3:0]  exp_sel;
        logic [31:0] exp_din;
        mis     = ref_misaligned(a_sz, a_ba[1:0]);
        n       = 1 << a_sz;
        exp_lat = mis ? 1 : (a_we ? 2 : 3);
        exp_sel = '0;
        exp_din = '0;
        if (!mis) begin
            for (int i = 0; i < n; i++) exp_sel[int'(a_ba[1:0]) + i] = 1'b1;
        end
        for (int l = 0; l < 4; l++) exp_din[8*l +: 8] = a_wd[8*(l % n) +: 8];
        chk("ready_idle", 32'(ready), 32'd1);
        req = 1'b1; we = a_we; size = a_sz; sign_ext = a_sx; byte_addr = a_ba; wdata = a_wd;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        lat = 1; nstr = 0; nld = 0;
        while (done !== 1'b1 && lat < 8) begin
            chk("ready_busy", 32'(ready), 32'd0);
            chk("strobe_excl", 32'(mem_str & mem_ld), 32'd0);
            if (mem_str === 1'b1) begin
                nstr++;
                chk("st_addr", 32'(mem_addr), 32'(a_ba[13:2]));
                chk("st_sel", 32'(mem_sel), 32'(exp_sel));
                chk("st_data", mem_datain, exp_din);
            end
            if (mem_ld === 1'b1) begin
                nld++;
                chk("ld_addr", 32'(mem_addr), 32'(a_ba[13:2]));
                chk("ld_sel", 32'(mem_sel), 32'(exp_sel));
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("done", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("misalign", 32'(misalign), 32'(mis));
        chk("str_count", 32'(nstr), 32'(a_we && !mis));
        chk("ld_count", 32'(nld), 32'(!a_we && !mis));
        chk("strobes_at_done", 32'({mem_str, mem_ld}), 32'd0);
        if (!mis) begin
            if (a_we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a_ba) + i] = a_wd[8*i +: 8];
            end else begin
                exp_rdata = ref_load(a_ba, a_sz, a_sx);
            end
        end
        chk("rdata", rdata, exp_rdata);
        if (!hold) begin
            @(posedge clk); #1;
            chk("done_pulse", 32'({done, misalign}), 32'd0);
            chk("ready_after", 32'(ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] prev;
        checks = 0; failures = 0; exp_rdata = '0;
        clr = 1'b1; req = 1'b0; we = 1'b0; size = '0; sign_ext = 1'b0;
        byte_addr = '0; wdata = '0;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'({done, misalign}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strobes", 32'({mem_str, mem_ld, mem_sel}), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_datain", mem_datain, 32'd0);
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;

        // Initialise the working region so every later load is defined.
        for (int w = 0; w < 18; w++) access(1'b1, 2'd2, 1'b0, 14'(4 * w), $urandom, 1'b0);

        access(1'b1, 2'd0, 1'b0, 14'h005, 32'h0000_00AB, 1'b0);
        access(1'b1, 2'd2, 1'b0, 14'h040, 32'h8001_1234, 1'b0);
        access(1'b0, 2'd1, 1'b1, 14'h042, 32'h0, 1'b0);
        chk("half_signed", rdata, 32'hFFFF_8001);
        access(1'b0, 2'd1, 1'b0, 14'h042, 32'h0, 1'b0);
        chk("half_unsigned", rdata, 32'h0000_8001);
        access(1'b0, 2'd0, 1'b0, 14'h043, 32'h0, 1'b0);
        chk("byte_unsigned", rdata, 32'h0000_0080);
        access(1'b0, 2'd0, 1'b1, 14'h043, 32'h0, 1'b0);
        chk("byte_signed", rdata, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 14'h040, 32'h0, 1'b0);
        chk("byte_signed_pos", rdata, 32'h0000_0034);

        prev = rdata;
        access(1'b0, 2'd2, 1'b0, 14'h006, 32'h0, 1'b0);
        access(1'b0, 2'd3, 1'b0, 14'h000, 32'h0, 1'b0);
        chk("mis_rdata_kept", rdata, prev);

        // req held high across a store: second store starts only after done.
        access(1'b1, 2'd1, 1'b0, 14'h012, 32'h0000_5A5A, 1'b1);
        @(posedge clk); #1;
        chk("hold_idle_ready", 32'(ready), 32'd1);
        chk("hold_idle_done", 32'(done), 32'd0);
        chk("hold_idle_str", 32'(mem_str), 32'd0);
        access(1'b1, 2'd1, 1'b0, 14'h012, 32'h0000_5A5A, 1'b0);

        // Reset during CAPTURE discards the load.
        access(1'b1, 2'd2, 1'b0, 14'h020, 32'hDEAD_BEEF, 1'b0);
        req = 1'b1; we = 1'b0; size = 2'd1; sign_ext = 1'b0; byte_addr = 14'h042;
        @(posedge clk); #1;
        req = 1'b0;
        chk("clr_ld_phase", 32'(mem_ld), 32'd1);
        @(posedge clk); #1;
        chk("clr_capture_ld", 32'(mem_ld), 32'd0);
        clr = 1'b1; #1;
        exp_rdata = '0;
        chk("clr_ready", 32'(ready), 32'd1);
        chk("clr_strobes", 32'({mem_ld, mem_str, done}), 32'd0);
        chk("clr_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        chk("clr_hold_done", 32'(done), 32'd0);
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;
        chk("clr_rel_done", 32'(done), 32'd0);
        chk("clr_rel_rdata", rdata, 32'd0);
        access(1'b0, 2'd2, 1'b0, 14'h020, 32'h0, 1'b0);
        chk("post_clr_word", rdata, 32'hDEAD_BEEF);

        // Random traffic over the initialised region.
        for (int k = 0; k < 120; k++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   14'($urandom_range(0, 71)), $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
